// File: rtl/cache_control_pkg.sv
// cache_control_pkg
//   Shared types for the L1 cache controller: set index type, controller
//   state encoding, physical-memory address-select codes and a saturating
//   counter helper used by the optional performance counters.
package cache_control_pkg;

  typedef logic [2:0] lc3b_c_set;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } cache_state_t;

  typedef enum logic [1:0] {
    PMEM_CPU  = 2'd0,
    PMEM_WAY0 = 2'd1,
    PMEM_WAY1 = 2'd2
  } pmem_addr_sel_t;

  // Write-back address comes from whichever way holds the victim line.
  function automatic pmem_addr_sel_t victim_addr_sel(input logic victim);
    return victim ? PMEM_WAY1 : PMEM_WAY0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cache_control_lru.sv
// lru_array
//   One LRU bit per set: the index of the least-recently-used way, which is
//   also the replacement victim. Combinational read, synchronous write,
//   asynchronous clear.
// Ports:
//   clk, reset_n   clock and async active-low reset
//   set            set index (shared by read and write)
//   rd_data        LRU bit of 'set'
//   we, wr_data    write enable and new LRU bit for 'set'
module lru_array #(
  parameter int SET_W    = 3,
  parameter int NUM_SETS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SET_W-1:0] set,
  output logic             rd_data,
  input  logic             we,
  input  logic             wr_data
);

  logic [NUM_SETS-1:0] lru_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lru_bits <= '0;
    end else if (we) begin
      lru_bits[set] <= wr_data;
    end
  end

  assign rd_data = lru_bits[set];

endmodule

// File: rtl/cache_control.sv
// cache_control
//   Controller for the 2-way set-associative L1 cache. Handles CPU hits,
//   dirty-victim write-back and line allocation; owns the per-set LRU bits.
//   No data passes through this block.
//
//   state      | meaning
//   IDLE       | lookup; hit completes the request, miss starts a fill
//   WRITE_BACK | dirty victim being written to physical memory
//   ALLOCATE   | line being read from physical memory into the victim
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   set                          set index of the CPU address
//   mem_read/mem_write/mem_resp  CPU handshake (resp is a one-cycle pulse)
//   way*_hit, way*_dirty         per-way status
//   way*_lru_in                  one-hot victim select to the ways
//   write_back                   line-load strobe to the ways
//   datamux_sel, writemux_sel    way input muxes
//   pmem_addr_sel                0 CPU, 1 way0, 2 way1 address
//   pmem_read/pmem_write/pmem_resp  physical memory handshake
//   hit_count, miss_count        performance counters
//
// Build option: CACHE_PERF_CNT_EN enables the saturating 16-bit hit/miss
// counters; otherwise both counter ports are tied to zero.
module cache_control
  import cache_control_pkg::*;
#(
  parameter int SET_W    = $bits(lc3b_c_set),
  parameter int NUM_SETS = 2**SET_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SET_W-1:0] set,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             way0_hit,
  input  logic             way1_hit,
  input  logic             way0_dirty,
  input  logic             way1_dirty,
  output logic             way0_lru_in,
  output logic             way1_lru_in,
  output logic             write_back,
  output logic             datamux_sel,
  output logic             writemux_sel,
  output logic [1:0]       pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  cache_state_t   state, state_nxt;
  pmem_addr_sel_t addr_sel;
  logic           victim;
  logic           lru_we;
  logic           lru_wdata;
  logic           req;
  logic           hit;
  logic           hit_way;
  logic           victim_dirty;

  lru_array #(
    .SET_W   (SET_W),
    .NUM_SETS(NUM_SETS)
  ) u_lru (
    .clk    (clk),
    .reset_n(reset_n),
    .set    (set),
    .rd_data(victim),
    .we     (lru_we),
    .wr_data(lru_wdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign req          = mem_read | mem_write;
  assign hit          = way0_hit | way1_hit;
  // Both ways hitting is illegal; way0 takes priority.
  assign hit_way      = ~way0_hit;
  assign victim_dirty = victim ? way1_dirty : way0_dirty;

  assign way0_lru_in   = ~victim;
  assign way1_lru_in   = victim;
  assign pmem_addr_sel = addr_sel;

  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    write_back   = 1'b0;
    datamux_sel  = 1'b0;
    writemux_sel = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    addr_sel     = PMEM_CPU;
    lru_we       = 1'b0;
    lru_wdata    = 1'b0;

    case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          lru_we    = 1'b1;
          lru_wdata = ~hit_way;
          // Read+write together is treated as a write.
          if (mem_write) begin
            writemux_sel = 1'b1;
            datamux_sel  = 1'b1;
          end
        end else if (req) begin
          state_nxt = victim_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        pmem_write = 1'b1;
        addr_sel   = victim_addr_sel(victim);
        if (pmem_resp) begin
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        // Line is installed even if the CPU dropped its request; the
        // following IDLE lookup produces the response.
        if (pmem_resp) begin
          write_back = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;
  logic        miss_evt;

  assign miss_evt = (state == IDLE) && (state_nxt != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (mem_resp) begin
        hit_q <= sat_inc16(hit_q);
      end
      if (miss_evt) begin
        miss_q <= sat_inc16(miss_q);
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control. The two cache ways are modelled here as tag /
// valid / dirty arrays; way hit and dirty inputs are derived from that model,
// and the expected controller behaviour (LRU victim, miss sequence, latency,
// counters) is computed from the cache's rules.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  set_i = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_resp;
  logic        way0_hit, way1_hit, way0_dirty, way1_dirty;
  logic        way0_lru_in, way1_lru_in;
  logic        write_back, datamux_sel, writemux_sel;
  logic [1:0]  pmem_addr_sel;
  logic        pmem_read, pmem_write;
  logic        pmem_resp = 1'b0;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  // Way model and reference state.
  bit valid_m [2][8];
  int tag_m   [2][8];
  bit dirty_m [2][8];
  bit lru_m   [8];
  int cur_tag = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .set          (set_i),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .way0_hit     (way0_hit),
    .way1_hit     (way1_hit),
    .way0_dirty   (way0_dirty),
    .way1_dirty   (way1_dirty),
    .way0_lru_in  (way0_lru_in),
    .way1_lru_in  (way1_lru_in),
    .write_back   (write_back),
    .datamux_sel  (datamux_sel),
    .writemux_sel (writemux_sel),
    .pmem_addr_sel(pmem_addr_sel),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always_comb begin
    way0_hit   = valid_m[0][set_i] && (tag_m[0][set_i] == cur_tag);
    way1_hit   = valid_m[1][set_i] && (tag_m[1][set_i] == cur_tag);
    way0_dirty = valid_m[0][set_i] && dirty_m[0][set_i];
    way1_dirty = valid_m[1][set_i] && dirty_m[1][set_i];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v;
  endfunction

  // Idle cycle on set s: checks victim select and that no strobe is active.
  task automatic idle_check(input int s);
    set_i = 3'(s);
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("idle_lru0", 32'(way0_lru_in), 32'(!lru_m[s]));
    check("idle_lru1", 32'(way1_lru_in), 32'(lru_m[s]));
    check("idle_strobes", 32'({mem_resp, write_back, pmem_read, pmem_write, writemux_sel, datamux_sel}), 32'd0);
    check("idle_addr", 32'(pmem_addr_sel), 32'd0);
    @(posedge clk); #1;
  endtask

  // Called at the negedge of the cycle in which the request should hit.
  task automatic hit_checks(input int s, input bit wr);
    check("hit_resp", 32'(mem_resp), 32'd1);
    check("hit_wmux", 32'(writemux_sel), 32'(wr));
    check("hit_dmux", 32'(datamux_sel), 32'(wr));
    check("hit_pmem", 32'({pmem_read, pmem_write, write_back}), 32'd0);
    check("hit_lru1", 32'(way1_lru_in), 32'(lru_m[s]));
    exp_hits = sat(exp_hits + 1);
  endtask

  // One CPU request, driven just after a rising edge.
  task automatic access(input int s, input int t, input bit rd, input bit wr,
                        input int d_wb, input int d_al, input bit drop);
    int  hw;
    bit  hit;
    bit  v;
    bit  resp_seen;
    set_i = 3'(s);
    cur_tag = t;
    mem_read = rd;
    mem_write = wr;
    hit = 1'b0;
    hw = 0;
    resp_seen = 1'b0;
    if (valid_m[0][s] && tag_m[0][s] == t) begin
      hit = 1'b1; hw = 0;
    end else if (valid_m[1][s] && tag_m[1][s] == t) begin
      hit = 1'b1; hw = 1;
    end
    v = lru_m[s];
    @(negedge clk);
    check("req_lru0", 32'(way0_lru_in), 32'(!v));
    check("req_addr", 32'(pmem_addr_sel), 32'd0);
    if (hit) begin
      hit_checks(s, wr);
      resp_seen = 1'b1;
    end else begin
      check("miss_resp", 32'(mem_resp), 32'd0);
      check("miss_pmem", 32'({pmem_read, pmem_write}), 32'd0);
      exp_misses = sat(exp_misses + 1);
      @(posedge clk); #1;
      if (drop) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      if (valid_m[v][s] && dirty_m[v][s]) begin
        for (int i = 0; i <= d_wb; i++) begin
          pmem_resp = (i == d_wb);
          @(negedge clk);
          check("wb_write", 32'(pmem_write), 32'd1);
          check("wb_read", 32'(pmem_read), 32'd0);
          check("wb_addr", 32'(pmem_addr_sel), 32'(1 + int'(v)));
          check("wb_resp", 32'({mem_resp, write_back}), 32'd0);
          @(posedge clk); #1;
        end
        pmem_resp = 1'b0;
      end
      for (int i = 0; i <= d_al; i++) begin
        pmem_resp = (i == d_al);
        @(negedge clk);
        check("al_read", 32'(pmem_read), 32'd1);
        check("al_write", 32'(pmem_write), 32'd0);
        check("al_addr", 32'(pmem_addr_sel), 32'd0);
        check("al_wb", 32'(write_back), 32'(i == d_al));
        check("al_resp", 32'(mem_resp), 32'd0);
        if (i == d_al) begin
          check("al_muxes", 32'({datamux_sel, writemux_sel}), 32'd0);
          check("al_lru1", 32'(way1_lru_in), 32'(v));
        end
        @(posedge clk); #1;
      end
      pmem_resp = 1'b0;
      valid_m[v][s] = 1'b1;
      tag_m[v][s] = t;
      dirty_m[v][s] = wr && !drop;
      hw = int'(v);
      @(negedge clk);
      if (drop) begin
        check("drop_resp", 32'(mem_resp), 32'd0);
        check("drop_pmem", 32'({pmem_read, pmem_write}), 32'd0);
      end else begin
        hit_checks(s, wr);
        resp_seen = 1'b1;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (resp_seen) begin
      lru_m[s] = (hw == 0);
      if (wr) dirty_m[hw][s] = 1'b1;
    end
  endtask

  task automatic check_counters(input string name);
`ifdef CACHE_PERF_CNT_EN
    check({name, "_hits"}, 32'(hit_count), 32'(exp_hits));
    check({name, "_misses"}, 32'(miss_count), 32'(exp_misses));
`else
    check({name, "_hits"}, 32'(hit_count), 32'd0);
    check({name, "_misses"}, 32'(miss_count), 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    check("rst_strobes", 32'({mem_resp, write_back, pmem_read, pmem_write, writemux_sel, datamux_sel}), 32'd0);
    check("rst_lru", 32'({way1_lru_in, way0_lru_in}), 32'b01);
    check("rst_addr", 32'(pmem_addr_sel), 32'd0);
    check("rst_cnt", 32'({hit_count, miss_count}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset during ALLOCATE aborts the fill immediately.
    set_i = 3'd0;
    cur_tag = 5;
    mem_read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_read", 32'(pmem_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_abort_read", 32'(pmem_read), 32'd0);
    check("rst_abort_cnt", 32'({hit_count, miss_count}), 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int s = 0; s < 8; s++) idle_check(s);

    // Directed: read hit on way1, set 3.
    valid_m[1][3] = 1'b1; tag_m[1][3] = 7;
    access(3, 7, 1'b1, 1'b0, 0, 0, 1'b0);
    idle_check(3);
    check("lru3_after_hit", 32'(way0_lru_in), 32'd1);

    // Directed: clean read miss on set 5 with lru[5]=1, 4-cycle fill.
    valid_m[0][5] = 1'b1; tag_m[0][5] = 1;
    access(5, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    access(5, 6, 1'b1, 1'b0, 0, 3, 1'b0);

    // Directed: dirty write miss on set 2 with lru[2]=0.
    valid_m[0][2] = 1'b1; tag_m[0][2] = 1; dirty_m[0][2] = 1'b1;
    valid_m[1][2] = 1'b1; tag_m[1][2] = 2;
    access(2, 9, 1'b0, 1'b1, 2, 1, 1'b0);

    // Directed: read and write together on a way0 hit is a write.
    valid_m[0][4] = 1'b1; tag_m[0][4] = 3;
    access(4, 3, 1'b1, 1'b1, 0, 0, 1'b0);
    check_counters("directed");

    // Randomized traffic; small tag space gives a mix of hits and misses.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(1, 3);
      access($urandom_range(0, 7), $urandom_range(0, 3), r[0], r[1],
             $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 4) == 0) idle_check($urandom_range(0, 7));
    end
    check_counters("random");

`ifdef CACHE_PERF_CNT_EN
    // Long hit stream drives the hit counter into saturation.
    valid_m[0][6] = 1'b1; tag_m[0][6] = 11;
    set_i = 3'd6;
    cur_tag = 11;
    mem_read = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    mem_read = 1'b0;
    lru_m[6] = 1'b1;
    exp_hits = sat(exp_hits + 70000);
    @(negedge clk);
    check("sat_hits", 32'(hit_count), 32'h0000FFFF);
    check_counters("sat");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
